// File: rtl/fnd_pkg.sv
// Shared types, segment codes and helpers for the summation-result FND display.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}.
package fnd_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } fnd_state_e;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Non-decimal nibbles fall back to blank so a corrupted register never lights garbage.
  function automatic logic [7:0] seg_encode(input logic [3:0] digit, input logic blank);
    logic [7:0] code;
    if (blank) begin
      code = SEG_BLANK;
    end else begin
      case (digit)
        4'd0:    code = SEG_0;
        4'd1:    code = SEG_1;
        4'd2:    code = SEG_2;
        4'd3:    code = SEG_3;
        4'd4:    code = SEG_4;
        4'd5:    code = SEG_5;
        4'd6:    code = SEG_6;
        4'd7:    code = SEG_7;
        4'd8:    code = SEG_8;
        4'd9:    code = SEG_9;
        default: code = SEG_BLANK;
      endcase
    end
    return code;
  endfunction

  function automatic logic [3:0] dd_adjust(input logic [3:0] nibble);
    logic [3:0] res;
    if (nibble >= 4'd5) begin
      res = nibble + 4'd3;
    end else begin
      res = nibble;
    end
    return res;
  endfunction

endpackage

// File: rtl/sum_fnd_controller_if.sv
// Result-load and FND-pin bundle between the upstream datapath, this display stage and the board.
interface sum_fnd_controller_if;
  logic       data_load;
  logic [7:0] data;
  logic       busy;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;

  modport master (output data_load, output data, input busy, input fnd_com, input fnd_data);
  modport slave  (input data_load, input data, output busy, output fnd_com, output fnd_data);
endinterface

// File: rtl/fnd_tick_gen.sv
// Free-running prescaler producing a one-cycle scan tick every CLK_FREQ_HZ/SCAN_HZ cycles.
module fnd_tick_gen #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int SCAN_HZ     = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int PERIOD_RAW = CLK_FREQ_HZ / SCAN_HZ;
  localparam int PERIOD     = (PERIOD_RAW < 1) ? 1 : PERIOD_RAW;
  localparam int CNT_W      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count and tick; tick is registered so the scan index sees a clean strobe.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = 1'b0;
    end
  end

  // Prescaler state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
endmodule

// File: rtl/sum_fnd_controller.sv
// Captures the 8-bit sum result, converts it to BCD by sequential double-dabble
// and scans it onto a 4-digit common-anode FND.
module sum_fnd_controller
  import fnd_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int SCAN_HZ     = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  sum_fnd_controller_if.slave  bus
);
  fnd_state_e  state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [1:0]  idx_q, idx_d;
  logic        tick_s;
  logic [11:0] bcd_adj_s;
  logic [19:0] dd_next_s;
  logic [7:0]  fnd_data_s;
  logic [3:0]  fnd_com_s;

  fnd_tick_gen #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .SCAN_HZ     (SCAN_HZ)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  // One double-dabble step: add-3 correction then shift {bcd, binary} left by one.
  always_comb begin
    bcd_adj_s = {dd_adjust(bcd_q[11:8]), dd_adjust(bcd_q[7:4]), dd_adjust(bcd_q[3:0])};
    dd_next_s = {bcd_adj_s[10:0], shift_q, 1'b0};
  end

  // Conversion FSM, pending-load slot and display-register update.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bcd_d        = bcd_q;
    step_d       = step_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    hund_d       = hund_q;
    tens_d       = tens_q;
    ones_d       = ones_q;
    case (state_q)
      IDLE: begin
        // A direct load outranks a stale pending value, which is then dropped.
        if (bus.data_load) begin
          shift_d      = bus.data;
          bcd_d        = 12'd0;
          step_d       = 3'd0;
          pend_valid_d = 1'b0;
          state_d      = CONV;
        end else if (pend_valid_q) begin
          shift_d      = pend_q;
          bcd_d        = 12'd0;
          step_d       = 3'd0;
          pend_valid_d = 1'b0;
          state_d      = CONV;
        end else begin
          state_d      = IDLE;
        end
      end
      CONV: begin
        {bcd_d, shift_d} = dd_next_s;
        step_d           = step_q + 3'd1;
        if (bus.data_load) begin
          pend_d       = bus.data;
          pend_valid_d = 1'b1;
        end else begin
          pend_valid_d = pend_valid_q;
        end
        if (step_q == 3'd7) begin
          hund_d  = dd_next_s[19:16];
          tens_d  = dd_next_s[15:12];
          ones_d  = dd_next_s[11:8];
          state_d = IDLE;
        end else begin
          state_d = CONV;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Scan index advance.
  always_comb begin
    if (tick_s) begin
      idx_d = idx_q + 2'd1;
    end else begin
      idx_d = idx_q;
    end
  end

  // State, conversion, pending, display and scan registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      shift_q      <= 8'd0;
      bcd_q        <= 12'd0;
      step_q       <= 3'd0;
      pend_q       <= 8'd0;
      pend_valid_q <= 1'b0;
      hund_q       <= 4'd0;
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
      idx_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bcd_q        <= bcd_d;
      step_q       <= step_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      hund_q       <= hund_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      idx_q        <= idx_d;
    end
  end

  // Digit select and leading-zero blanking; depends only on registers.
  always_comb begin
    fnd_com_s = ~(4'b0001 << idx_q);
    case (idx_q)
      2'd0:    fnd_data_s = seg_encode(ones_q, 1'b0);
      2'd1:    fnd_data_s = seg_encode(tens_q, (hund_q == 4'd0) && (tens_q == 4'd0));
      2'd2:    fnd_data_s = seg_encode(hund_q, hund_q == 4'd0);
      2'd3:    fnd_data_s = SEG_BLANK;
      default: fnd_data_s = SEG_BLANK;
    endcase
  end

  assign bus.busy     = (state_q == CONV);
  assign bus.fnd_com  = fnd_com_s;
  assign bus.fnd_data = fnd_data_s;
endmodule
